complex_mult_seq: RTL and testbench
===================================

// Module: complex_mult_seq
// PURPOSE
//   Sequential complex multiplier controller. Time-shares one external truncated
//   real multiplier (multiplierkaratrunc-style, S = low DATA_W bits of A*B) over
//   four cycles to form P = A*B or P = A*conj(B) on DATA_W-bit complex operands.
//   Sits between the amplitude-update stage (requester, valid/ready) and the
//   single shared multiplier instance in the gate-application datapath.
// PARAMETERS
//   DATA_W  32  width of each real/imag component, operands, products, results
// PORTS
//   clk        in   1       clock; all state updates on rising edge
//   rst_n      in   1       asynchronous active-low reset
//   in_valid   in   1       request valid
//   in_ready   out  1       controller can accept a request
//   conj_b     in   1       0: P=A*B, 1: P=A*conj(B); sampled at accept
//   a_re,a_im  in   DATA_W  operand A, sampled at accept
//   b_re,b_im  in   DATA_W  operand B, sampled at accept
//   mul_a      out  DATA_W  operand A to shared multiplier
//   mul_b      out  DATA_W  operand B to shared multiplier
//   mul_s      in   DATA_W  combinational product from multiplier, same cycle
//   out_valid  out  1       result valid
//   out_ready  in   1       consumer accepts result
//   p_re,p_im  out  DATA_W  result, registered
//   busy       out  1       state != IDLE
// BEHAVIOUR
//   Reset (rst_n=0, async): state=IDLE; out_valid=0; p_re=p_im=0; mul_a=mul_b=0;
//     busy=0; in_ready=1 once reset is deasserted; operand regs, conj flag, accumulators cleared.
//   States: IDLE -> M0 -> M1 -> M2 -> M3 -> DONE -> IDLE.
//   IDLE: in_ready=1. On in_valid&&in_ready edge: latch a_*, b_*, conj_b -> M0.
//     No accept in any other state (in_ready=0).
//   mul_a/mul_b: combinational from state and latched operands; 0 in IDLE/DONE.
//     M0: ar*br   M1: ai*bi   M2: ar*bi   M3: ai*br
//   Accumulate on each M-state edge; all arithmetic mod 2^DATA_W, no saturation:
//     M0: re<=S        M1: re<=re-S (conj: re+S)
//     M2: im<=S        M3: im<=S+im (conj: S-im), p_re/p_im<=final re/im,
//                      out_valid<=1 -> DONE
//   Latency: accept at edge E0, out_valid=1 after edge E0+4. Throughput: one
//     result per 6 cycles when out_ready is held high.
//   DONE: out_valid, p_re and p_im held stable while out_ready=0 (no limit).
//     out_valid&&out_ready edge: out_valid<=0 -> IDLE. p_re/p_im keep last
//     value until next M3 update.
//   Inputs a_*, b_*, conj_b may change freely after accept; no effect on result.
//   in_valid in non-IDLE states ignored; requester must hold until in_ready.
//   rst_n asserted mid-operation: transaction dropped, no out_valid, all
//     outputs to reset values immediately.
//   Signedness: truncated low bits are sign-agnostic; results equal two's
//     complement fixed-point product mod 2^DATA_W (no rescaling here).
// TESTING (DATA_W=32)
//   1 A=(3,4) B=(5,-2) conj=0 -> after 4 cycles out_valid=1, p_re=23, p_im=14;
//     mul_a/mul_b sequence (3,5),(4,-2),(3,-2),(4,5).
//   2 Same operands conj=1 -> p_re=7, p_im=26.
//   3 Wrap: A=(0x80000000,0x00010000) B=(2,0x00010000) conj=0 -> p_re=0,
//     p_im=0x00020000 (ar*bi=0 mod 2^32; im=ai*br).
//   4 Backpressure: out_ready=0 for 10 cycles in DONE -> out_valid, p_re, p_im
//     stable, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next edge.
//   5 Back-to-back: in_valid and out_ready held 1, 3 requests -> results in
//     order, accepts 6 cycles apart, no lost or duplicated results.
//   6 rst_n low during M2 -> out_valid never asserts, in_ready=1 once rst_n
//     released, next request computes correctly from clean state.

Source files
------------

// File: rtl/complex_mult_seq.sv
// Sequential complex multiplier controller.
// Shares one truncated real multiplier over four cycles per product.
module complex_mult_seq #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              conj_b,
  input  logic [DATA_W-1:0] a_re,
  input  logic [DATA_W-1:0] a_im,
  input  logic [DATA_W-1:0] b_re,
  input  logic [DATA_W-1:0] b_im,
  output logic [DATA_W-1:0] mul_a,
  output logic [DATA_W-1:0] mul_b,
  input  logic [DATA_W-1:0] mul_s,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] p_re,
  output logic [DATA_W-1:0] p_im,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE, M0, M1, M2, M3, DONE
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_ar;
  logic [DATA_W-1:0] r_ai;
  logic [DATA_W-1:0] r_br;
  logic [DATA_W-1:0] r_bi;
  logic              r_conj;
  logic [DATA_W-1:0] r_re;
  logic [DATA_W-1:0] r_im;
  logic [DATA_W-1:0] r_p_re;
  logic [DATA_W-1:0] r_p_im;
  logic              r_out_valid;

  logic              w_idle;
  logic [DATA_W-1:0] w_re_acc;
  logic [DATA_W-1:0] w_im_fin;

  assign w_idle   = (r_state == IDLE);
  assign in_ready = w_idle && rst_n;
  assign busy     = !w_idle;

  assign out_valid = r_out_valid;
  assign p_re      = r_p_re;
  assign p_im      = r_p_im;

  // conj flips the sign of every bi term
  assign w_re_acc = r_conj ? r_re + mul_s : r_re - mul_s;
  assign w_im_fin = r_conj ? mul_s - r_im : mul_s + r_im;

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    unique case (r_state)
      M0: begin
        mul_a = r_ar;
        mul_b = r_br;
      end
      M1: begin
        mul_a = r_ai;
        mul_b = r_bi;
      end
      M2: begin
        mul_a = r_ar;
        mul_b = r_bi;
      end
      M3: begin
        mul_a = r_ai;
        mul_b = r_br;
      end
      default: begin
        mul_a = '0;
        mul_b = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ar        <= '0;
      r_ai        <= '0;
      r_br        <= '0;
      r_bi        <= '0;
      r_conj      <= 1'b0;
      r_re        <= '0;
      r_im        <= '0;
      r_p_re      <= '0;
      r_p_im      <= '0;
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_ar    <= a_re;
            r_ai    <= a_im;
            r_br    <= b_re;
            r_bi    <= b_im;
            r_conj  <= conj_b;
            r_state <= M0;
          end
        end
        M0: begin
          r_re    <= mul_s;
          r_state <= M1;
        end
        M1: begin
          r_re    <= w_re_acc;
          r_state <= M2;
        end
        M2: begin
          r_im    <= mul_s;
          r_state <= M3;
        end
        M3: begin
          r_im        <= w_im_fin;
          r_p_re      <= r_re;
          r_p_im      <= w_im_fin;
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_complex_mult_seq.sv
// Bench for complex_mult_seq: vector table, corner sequences,
// and random operands against a complex-arithmetic model.
module tb_complex_mult_seq;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic         conj_b;
  logic [W-1:0] a_re, a_im, b_re, b_im;
  logic [W-1:0] mul_a, mul_b, mul_s;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] p_re, p_im;
  logic         busy;
  logic [63:0]  w_prod;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] seq_a [4];
  logic [W-1:0] seq_b [4];

  complex_mult_seq #(.DATA_W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .conj_b(conj_b),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
    .mul_a(mul_a), .mul_b(mul_b), .mul_s(mul_s),
    .out_valid(out_valid), .out_ready(out_ready),
    .p_re(p_re), .p_im(p_im), .busy(busy)
  );

  // the shared truncating multiplier
  assign w_prod = {32'b0, mul_a} * {32'b0, mul_b};
  assign mul_s  = w_prod[31:0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         cj;
    logic [W-1:0] ar, ai, br, bi;
    logic [W-1:0] er, ei;
  } vec_t;

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // (ar+j ai)(br +/- j bi) mod 2^32
  task automatic model(input logic cj,
                       input logic [W-1:0] ar, ai, br, bi,
                       output logic [W-1:0] er, ei);
    logic [63:0] rr, ii, ir, ri, re, im;
    rr = {32'b0, ar} * {32'b0, br};
    ii = {32'b0, ai} * {32'b0, bi};
    ir = {32'b0, ai} * {32'b0, br};
    ri = {32'b0, ar} * {32'b0, bi};
    re = cj ? rr + ii : rr - ii;
    im = cj ? ir - ri : ir + ri;
    er = re[31:0];
    ei = im[31:0];
  endtask

  // one full transaction; returns result and cycles from accept to valid
  task automatic txn(input logic cj, input logic [W-1:0] ar, ai, br, bi,
                     output logic [W-1:0] rr, ri, output int lat);
    int k;
    lat = -1;
    rr  = '0;
    ri  = '0;
    k   = 0;
    @(negedge clk);
    while (!in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    conj_b = cj; a_re = ar; a_im = ai; b_re = br; b_im = bi;
    in_valid = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (n == 1) begin
        in_valid = 1'b0;
        conj_b = ~cj;
        a_re = $urandom; a_im = $urandom;
        b_re = $urandom; b_im = $urandom;
      end
      if (n <= 4) begin
        seq_a[n-1] = mul_a;
        seq_b[n-1] = mul_b;
      end
      if (out_valid) begin
        lat = n - 1;
        break;
      end
    end
    if (lat < 0) begin
      errors++;
      checks++;
      $display("FAIL timeout waiting out_valid");
    end else begin
      rr = p_re;
      ri = p_im;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  vec_t         tbl [6];
  logic [W-1:0] gr, gi, er, ei;
  int           lat;

  initial begin
    tbl[0] = '{1'b0, 32'd3, 32'd4, 32'd5, -32'sd2, 32'd23, 32'd14};
    tbl[1] = '{1'b1, 32'd3, 32'd4, 32'd5, -32'sd2, 32'd7, 32'd26};
    tbl[2] = '{1'b0, 32'h80000000, 32'h00010000, 32'd2, 32'h00010000,
               32'd0, 32'h00020000};
    tbl[3] = '{1'b0, -32'sd1, -32'sd1, -32'sd1, 32'd1, 32'd2, 32'd0};
    tbl[4] = '{1'b1, 32'd1, 32'd2, 32'd3, 32'd4, 32'd11, 32'd2};
    tbl[5] = '{1'b1, 32'd0, 32'd0, 32'hdeadbeef, 32'h12345678, 32'd0, 32'd0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; conj_b = 1'b0;
    a_re = '0; a_im = '0; b_re = '0; b_im = '0;
    #3;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_p_re", p_re, 32'd0);
    chk("rst_p_im", p_im, 32'd0);
    chk("rst_mul_a", mul_a, 32'd0);
    chk("rst_mul_b", mul_b, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

    for (int i = 0; i < 6; i++) begin
      txn(tbl[i].cj, tbl[i].ar, tbl[i].ai, tbl[i].br, tbl[i].bi, gr, gi, lat);
      chk($sformatf("vec%0d_re", i), gr, tbl[i].er);
      chk($sformatf("vec%0d_im", i), gi, tbl[i].ei);
      chk($sformatf("vec%0d_lat", i), lat, 32'd4);
    end

    // operand sequence presented to the multiplier
    txn(1'b0, 32'd3, 32'd4, 32'd5, -32'sd2, gr, gi, lat);
    chk("seq_a0", seq_a[0], 32'd3);  chk("seq_b0", seq_b[0], 32'd5);
    chk("seq_a1", seq_a[1], 32'd4);  chk("seq_b1", seq_b[1], -32'sd2);
    chk("seq_a2", seq_a[2], 32'd3);  chk("seq_b2", seq_b[2], -32'sd2);
    chk("seq_a3", seq_a[3], 32'd4);  chk("seq_b3", seq_b[3], 32'd5);

    // backpressure in DONE
    @(negedge clk);
    conj_b = 1'b0; a_re = 32'd3; a_im = 32'd4; b_re = 32'd5; b_im = -32'sd2;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int n = 0; n < 10 && !out_valid; n++) @(negedge clk);
    chk("bp_valid_seen", {31'b0, out_valid}, 32'd1);
    for (int n = 0; n < 10; n++) begin
      in_valid = 1'b1;
      a_re = $urandom; b_re = $urandom;
      @(negedge clk);
      chk("bp_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_re", p_re, 32'd23);
      chk("bp_im", p_im, 32'd14);
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_release_valid", {31'b0, out_valid}, 32'd0);
    chk("bp_release_busy", {31'b0, busy}, 32'd0);
    chk("bp_release_ready", {31'b0, in_ready}, 32'd1);
    chk("bp_hold_re", p_re, 32'd23);

    // back-to-back with in_valid and out_ready held high
    begin
      logic [W-1:0] xr [3], xi [3], qa [3], qb [3], qc [3], qd [3];
      logic         qj [3];
      int acc_cyc [3];
      int na, nr, cyc;
      logic acc, ov;
      for (int k = 0; k < 3; k++) begin
        qa[k] = $urandom; qb[k] = $urandom;
        qc[k] = $urandom; qd[k] = $urandom;
        qj[k] = k[0];
        model(qj[k], qa[k], qb[k], qc[k], qd[k], xr[k], xi[k]);
      end
      na = 0; nr = 0; cyc = 0;
      conj_b = qj[0]; a_re = qa[0]; a_im = qb[0]; b_re = qc[0]; b_im = qd[0];
      in_valid = 1'b1;
      out_ready = 1'b1;
      while (nr < 3 && cyc < 60) begin
        acc = in_valid && in_ready;
        ov  = out_valid;
        if (ov) begin
          chk($sformatf("b2b%0d_re", nr), p_re, xr[nr]);
          chk($sformatf("b2b%0d_im", nr), p_im, xi[nr]);
          nr++;
        end
        @(posedge clk);
        #1;
        if (acc) begin
          acc_cyc[na] = cyc;
          na++;
          if (na < 3) begin
            conj_b = qj[na]; a_re = qa[na]; a_im = qb[na];
            b_re = qc[na]; b_im = qd[na];
          end else begin
            in_valid = 1'b0;
          end
        end
        cyc++;
        @(negedge clk);
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      chk("b2b_results", nr, 32'd3);
      chk("b2b_accepts", na, 32'd3);
      if (na == 3) begin
        chk("b2b_gap1", acc_cyc[1] - acc_cyc[0], 32'd6);
        chk("b2b_gap2", acc_cyc[2] - acc_cyc[1], 32'd6);
      end
    end

    // reset asserted during M2
    @(negedge clk);
    conj_b = 1'b0; a_re = 32'd7; a_im = 32'd9; b_re = 32'd11; b_im = 32'd13;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("pre_rst_mul_a", mul_a, 32'd7);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_p_re", p_re, 32'd0);
    chk("mid_rst_mul_a", mul_a, 32'd0);
    begin
      int seen;
      seen = 0;
      for (int n = 0; n < 3; n++) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      rst_n = 1'b1;
      #1;
      chk("post_rst_ready", {31'b0, in_ready}, 32'd1);
      for (int n = 0; n < 8; n++) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      chk("post_rst_no_valid", seen, 32'd0);
    end
    txn(1'b1, 32'd7, 32'd9, 32'd11, 32'd13, gr, gi, lat);
    model(1'b1, 32'd7, 32'd9, 32'd11, 32'd13, er, ei);
    chk("post_rst_re", gr, er);
    chk("post_rst_im", gi, ei);

    // random operands
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb, rc, rd;
      logic         rj;
      ra = $urandom; rb = $urandom; rc = $urandom; rd = $urandom;
      rj = 1'($urandom_range(0, 1));
      model(rj, ra, rb, rc, rd, er, ei);
      txn(rj, ra, rb, rc, rd, gr, gi, lat);
      chk($sformatf("rnd%0d_re", i), gr, er);
      chk($sformatf("rnd%0d_im", i), gi, ei);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
